// File: rtl/sa_ram_rwsp_32x32_fifo_ctrl.sv
// sa_ram_rwsp_32x32_fifo_ctrl: valid/ready FIFO front end for the 32x32 read/write single-port RAM.
// Ports: nvdla_core_clk/nvdla_core_rstn clock and async active-low reset;
//   wr_pvld/wr_prdy/wr_pd push stream; rd_pvld/rd_prdy/rd_pd pop stream;
//   ram_wa/ram_we/ram_di RAM write port; ram_ra/ram_re/ram_ore/ram_dout RAM read port;
//   pwrbus_ram_pd -> ram_pwrbus_pd power bus pass-through.
// Optional: define SA_RAM_FIFO_COUNT_EN to add the registered fifo_cnt occupancy output.
module sa_ram_rwsp_32x32_fifo_ctrl #(
    parameter int DEPTH      = 32,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int SKID_DEPTH = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_pd
`ifdef SA_RAM_FIFO_COUNT_EN
    ,output logic [5:0]   fifo_cnt
`endif
);
    localparam int SW = $clog2(SKID_DEPTH);

    logic          rdy_en, ore_q, cap_q, pop;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [AW:0]   ram_cnt, avail;
    logic [SW:0]   skid_cnt, occ;
    logic [SW-1:0] wp, rp;
    logic [DW-1:0] skid [SKID_DEPTH];

    // ram_cnt only drops at the ore edge, so a slot is never rewritten before its data is captured
    assign wr_prdy       = rdy_en & (ram_cnt < (AW+1)'(DEPTH));
    assign ram_we        = wr_pvld & wr_prdy;
    assign ram_wa        = wr_adr;
    assign ram_di        = wr_pd;
    // words already issued (ore and capture stages) reserve their skid slot in advance
    assign occ           = skid_cnt + (SW+1)'(ore_q) + (SW+1)'(cap_q);
    assign ram_re        = (avail != '0) & (occ < (SW+1)'(SKID_DEPTH));
    assign ram_ra        = rd_adr;
    assign ram_ore       = ore_q;
    assign rd_pvld       = skid_cnt != '0;
    assign rd_pd         = skid[rp];
    assign pop           = rd_pvld & rd_prdy;
    assign ram_pwrbus_pd = pwrbus_ram_pd;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rdy_en   <= 1'b0;
            wr_adr   <= '0;
            rd_adr   <= '0;
            ram_cnt  <= '0;
            avail    <= '0;
            ore_q    <= 1'b0;
            cap_q    <= 1'b0;
            skid_cnt <= '0;
            wp       <= '0;
            rp       <= '0;
`ifdef SA_RAM_FIFO_COUNT_EN
            fifo_cnt <= '0;
`endif
        end else begin
            rdy_en   <= 1'b1;
            wr_adr   <= wr_adr + AW'(ram_we);
            rd_adr   <= rd_adr + AW'(ram_re);
            ram_cnt  <= ram_cnt + (AW+1)'(ram_we) - (AW+1)'(ore_q);
            avail    <= avail + (AW+1)'(ram_we) - (AW+1)'(ram_re);
            ore_q    <= ram_re;
            cap_q    <= ore_q;
            skid_cnt <= skid_cnt + (SW+1)'(cap_q) - (SW+1)'(pop);
            wp       <= wp + SW'(cap_q);
            rp       <= rp + SW'(pop);
`ifdef SA_RAM_FIFO_COUNT_EN
            fifo_cnt <= fifo_cnt + 6'(ram_we) - 6'(pop);
`endif
        end
    end

    // ram_dout is valid in the cycle after ore; capture it then
    always_ff @(posedge nvdla_core_clk) begin
        if (cap_q) skid[wp] <= ram_dout;
    end
endmodule

// File: tb/tb_sa_ram_rwsp_32x32_fifo_ctrl.sv
// tb_sa_ram_rwsp_32x32_fifo_ctrl: scoreboard bench for the RAM FIFO controller with a behavioural RAM.
module tb_sa_ram_rwsp_32x32_fifo_ctrl;
    localparam int DW = 32, AW = 5, DEPTH = 32, SK = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we, ram_re, ram_ore;
    logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [31:0]   pwr_in, pwr_out;
`ifdef SA_RAM_FIFO_COUNT_EN
    logic [5:0]    fifo_cnt;
`endif

    always #5 clk = ~clk;

    sa_ram_rwsp_32x32_fifo_ctrl dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .pwrbus_ram_pd(pwr_in), .ram_pwrbus_pd(pwr_out)
`ifdef SA_RAM_FIFO_COUNT_EN
        , .fifo_cnt(fifo_cnt)
`endif
    );

    // behavioural RAM: re latches the address, ore registers the addressed word
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_d;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) ram_dout <= mem[ra_d];
    end

    int compared = 0, mismatched = 0;
    int cyc = 0, issued = 0, pushed_n = 0, popped_n = 0, last_pop_cyc = 0;
    bit rdy_ok = 0, stall_prev = 0;
    logic [DW-1:0] pd_prev;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: samples every handshake at the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_vld", rd_pvld, 1);
                chk("hold_pd", rd_pd, pd_prev);
            end
`ifdef SA_RAM_FIFO_COUNT_EN
            chk("fifo_cnt", fifo_cnt, pushed_n - popped_n);
`endif
            if (ram_re) issued++;
            compared++;
            if (issued - popped_n > SK) begin
                mismatched++;
                $display("FAIL inflight_bound: got %0d limit %0d", issued - popped_n, SK);
            end
            if (rdy_ok && pushed_n - popped_n < DEPTH) chk("wr_prdy_free", wr_prdy, 1);
            if (rd_pvld && rd_prdy) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL pop_unexpected: got %0h expected no data", rd_pd);
                end else begin
                    compared--;
                    chk("pop_data", rd_pd, exp_q.pop_front());
                end
                popped_n++;
                last_pop_cyc = cyc;
            end
            if (wr_pvld && wr_prdy) begin
                exp_q.push_back(wr_pd);
                pushed_n++;
            end
            stall_prev = rd_pvld && !rd_prdy;
            pd_prev = rd_pd;
        end else begin
            stall_prev = 0;
            issued = 0;
            pushed_n = 0;
            popped_n = 0;
            exp_q.delete();
        end
    end

    task automatic drain(input string name);
        int n = 0;
        rd_prdy = 1;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (6) @(negedge clk);
        chk({name, "_idle"}, rd_pvld, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wr_prdy"}, wr_prdy, 0);
        chk({tag, "_rd_pvld"}, rd_pvld, 0);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_re"}, ram_re, 0);
        chk({tag, "_ore"}, ram_ore, 0);
        chk({tag, "_wa"}, ram_wa, 0);
        chk({tag, "_ra"}, ram_ra, 0);
    endtask

    initial begin
        int acc, c0, base, t;
        wr_pvld = 0; wr_pd = '0; rd_prdy = 0; pwr_in = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        wr_pvld = 1;
        #1;
        reset_checks("rst");
        chk("pwrbus", pwr_out, 32'h1234_5678);
        wr_pvld = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("wr_prdy_after_rst", wr_prdy, 1);
        rdy_ok = 1;

        // single word latency
        rd_prdy = 1; wr_pvld = 1; wr_pd = 32'hA5A5_0001;
        @(negedge clk);
        chk("lat_we", ram_we, 1); chk("lat_wa", ram_wa, 0); chk("lat_di", ram_di, 32'hA5A5_0001);
        chk("lat_re0", ram_re, 0);
        @(posedge clk); #1 wr_pvld = 0;
        @(negedge clk);
        chk("lat_re1", ram_re, 1); chk("lat_ra1", ram_ra, 0); chk("lat_ore1", ram_ore, 0);
        @(negedge clk);
        chk("lat_ore2", ram_ore, 1); chk("lat_re2", ram_re, 0); chk("lat_vld2", rd_pvld, 0);
        @(negedge clk);
        chk("lat_vld3", rd_pvld, 0);
        @(negedge clk);
        chk("lat_vld4", rd_pvld, 1); chk("lat_pd4", rd_pd, 32'hA5A5_0001);
        drain("lat_drain");

        // fill with rd_prdy low: RAM (32) plus skid (4) hold exactly 36 words
        @(posedge clk); #1 rd_prdy = 0;
        acc = 0;
        for (int i = 0; i < 60; i++) begin
            wr_pvld = 1; wr_pd = 32'h1000 + acc;
            @(negedge clk);
            if (wr_prdy) acc++;
            @(posedge clk); #1;
        end
        chk("full_count", acc, DEPTH + SK);
        chk("full_wr_prdy", wr_prdy, 0);
        chk("full_rd_pvld", rd_pvld, 1);
        wr_pvld = 0;
        drain("full_drain");

        // continuous streaming of 100 words
        @(posedge clk); #1;
        base = popped_n;
        c0 = cyc + 1;
        for (int i = 0; i < 100; i++) begin
            wr_pvld = 1; wr_pd = i;
            @(posedge clk); #1;
        end
        wr_pvld = 0;
        t = 0;
        while (popped_n < base + 100 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("stream_pops", popped_n - base, 100);
        chk("stream_span", last_pop_cyc - c0, 103);
        drain("stream_drain");

        // randomized push/pop with periods of 1,0,0,1 backpressure
        @(posedge clk); #1;
        for (int i = 0; i < 800; i++) begin
            wr_pvld = $urandom_range(0, 3) != 0;
            wr_pd = $urandom;
            rd_prdy = (i % 200 < 100) ? !((i % 4 == 1) || (i % 4 == 2)) : ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        wr_pvld = 0;
        drain("rand_drain");

        // reset with buffered data
        @(posedge clk); #1 rd_prdy = 0;
        for (int i = 0; i < 10; i++) begin
            wr_pvld = 1; wr_pd = 32'h2000 + i;
            @(posedge clk); #1;
        end
        wr_pvld = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_vld", rd_pvld, 1);
        rst_n = 0; rdy_ok = 0; wr_pvld = 1;
        #1;
        reset_checks("midrst");
        wr_pvld = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1 rdy_ok = 1; rd_prdy = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_vld", rd_pvld, 0);
        end
        @(posedge clk); #1 wr_pvld = 1; wr_pd = 32'hBEEF_0001;
        @(posedge clk); #1 wr_pvld = 0;
        drain("post_rst_drain");
        chk("post_rst_pops", popped_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
